// File: rtl/seq_shift_unit_pkg.sv
// rtl/seq_shift_unit_pkg.sv - shared encodings for the sequential shifter
//
// Purpose: single source of the shift-mode and FSM-state encodings used by
// the shifter, its one-position helper and the ALU decoder.
//
// Contents:
//   shift_op_e : OP_SLL, OP_SRL, OP_SRA, OP_ROR (2-bit, matches the op port)
//   state_e    : ST_IDLE, ST_SHIFT, ST_DONE
//   OP_W       : width of the op field

package seq_shift_unit_pkg;

  localparam int OP_W = 2;

  // Encoding values are fixed: the ALU decoder drives op with these codes.
  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_unit_if.sv
// rtl/seq_shift_unit_if.sv - request/result bundle of the sequential shifter
//
// Purpose: groups the start/busy/done handshake with its operand and result.
//
// Signals:
//   start  request, only honoured while the shifter is idle
//   op     shift mode (shift_op_e encoding)
//   a      operand
//   shamt  shift amount
//   busy   shifter occupied
//   done   one-cycle completion pulse
//   s      result, held until the next completion or reset
//
// Modports:
//   master : requester (ALU side) drives start/op/a/shamt
//   slave  : the shifter drives busy/done/s

interface seq_shift_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;

  modport master (
    output start, op, a, shamt,
    input  busy, done, s
  );

  modport slave (
    input  start, op, a, shamt,
    output busy, done, s
  );

endinterface

// File: rtl/seq_shift_unit_shift_one.sv
// rtl/seq_shift_unit_shift_one.sv - combinational single-position shifter
//
// Purpose: moves a WIDTH-bit word by exactly one bit position in the
// selected mode. Purely combinational.
//
// Ports:
//   d   in  WIDTH  word before the step
//   op  in  2      shift mode (shift_op_e)
//   q   out WIDTH  word after the step

module shift_one
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    unique case (op)
      OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROR:  q = {d[0], d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter, one bit position per clock
//
// Purpose: shifts a WIDTH-bit operand by shamt positions (SLL/SRL/SRA/ROR)
// under a start/busy/done handshake. A request is accepted only in IDLE;
// the operand, amount and mode are captured at that edge and never
// re-sampled until the operation finishes.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous, active-high reset; discards any operation
//   bus  slave modport of seq_shift_unit_if
//          start/op/a/shamt in, busy/done/s out
//
// Timing: accept at E0, done high in the cycle after E(shamt+1), back in
// IDLE after E(shamt+2). busy decodes the state register; done and s are
// registered, so no output depends combinationally on an input.

module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  seq_shift_unit_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  shift_op_e        mode_q;
  logic [WIDTH-1:0] s_q;
  logic             done_q;
  logic [WIDTH-1:0] work_step;

  // Control strobes decoded by the FSM for the datapath registers.
  logic accept;
  logic step;
  logic finish;

  shift_one #(
    .WIDTH (WIDTH)
  ) u_shift_one (
    .d  (work_q),
    .op (mode_q),
    .q  (work_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The zero-count check comes after the last step, so shamt=0
        // still spends one SHIFT cycle and finishes with s=a.
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      mode_q <= OP_SLL;
      s_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        work_q <= bus.a;
        cnt_q  <= bus.shamt;
        mode_q <= shift_op_e'(bus.op);
      end else if (step) begin
        work_q <= work_step;
        cnt_q  <= cnt_q - SHW'(1);
      end
      // s only moves on completion so the previous result stays visible
      // to the ALU for the whole of the next operation.
      if (finish) begin
        s_q <= work_q;
      end
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.s    = s_q;

endmodule
